random_map_writer: RTL and testbench

RANDOM_MAP_WRITER -- requirements
Module: random_map_writer

---
 rtl/random_map_writer.sv | 186 ++++++++++++++++++
 tb/tb_random_map_writer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/random_map_writer.sv
//-----------------------------------------------------------------------------
// random_map_writer
//
// Fills a CELLS_X x CELLS_Y occupancy map with pseudo-random bits from a
// 16-bit Fibonacci LFSR. The map is row-major (index = y*CELLS_X + x). One cell
// is written per clock while busy. A registered random-access read port lets
// the rest of the system query any cell at any time.
//
// Parameters
//   CELLS_X    grid width in cells  (default 32)
//   CELLS_Y    grid height in cells (default 24)
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      regenerate request, honoured only while idle
//   seed       LFSR seed, latched on an accepted start (0 maps to 16'hACE1)
//   density    occupancy threshold 0..16, larger values behave as 16
//   rd_x/rd_y  read-port cell coordinates
//   rd_occ     registered occupancy of cell (rd_x, rd_y), 0 when out of range
//   busy       high while the map is being written
//   done       one-cycle pulse after the last cell has been written
//   occ_count  number of occupied cells written by the last/current fill
//
// Build option
//   SAFE_SPAWN_EN  when defined, the 2x2 corner at (0,0) is always written
//                  empty and not counted; the LFSR still advances there.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module random_map_writer #(
    parameter int CELLS_X = 32,
    parameter int CELLS_Y = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [15:0] seed,
    input  logic [4:0] density,
    input  logic [4:0] rd_x,
    input  logic [4:0] rd_y,
    output logic       rd_occ,
    output logic       busy,
    output logic       done,
    output logic [9:0] occ_count
);

    localparam int          NCELLS       = CELLS_X * CELLS_Y;
    localparam int          IDX_W        = $clog2(NCELLS);
    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [NCELLS-1:0] map;
    logic [IDX_W-1:0]  idx;
    logic [15:0]       lfsr;
    logic [15:0]       lfsr_next;
    logic [4:0]        density_q;

    logic              start_accept;
    logic              last_cell;
    logic              cell_bit;

    logic [IDX_W-1:0]  rd_lin;
    logic              rd_valid;

    assign start_accept = (state == IDLE) && start;
    assign last_cell    = (idx == IDX_W'(NCELLS - 1));

    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

`ifdef SAFE_SPAWN_EN
    // Column/row trackers that follow idx, so the spawn corner can be detected
    // without a divider for arbitrary CELLS_X.
    logic [IDX_W-1:0] col;
    logic [IDX_W-1:0] row;
    logic             in_spawn;

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (start_accept) begin
            col <= '0;
            row <= '0;
        end else if (state == FILL) begin
            if (col == IDX_W'(CELLS_X - 1)) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign in_spawn = (col < IDX_W'(2)) && (row < IDX_W'(2));
    assign cell_bit = ({1'b0, lfsr[3:0]} < density_q) && !in_spawn;
`else
    assign cell_bit = ({1'b0, lfsr[3:0]} < density_q);
`endif

    //-------------------------------------------------------------------------
    // FSM: state register
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    //-------------------------------------------------------------------------
    // FSM: next-state logic. A start seen outside IDLE is simply dropped.
    //-------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = FILL;
            FILL: if (last_cell) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    //-------------------------------------------------------------------------
    // FSM: outputs, decoded straight from the state.
    //-------------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            FILL:    busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    //-------------------------------------------------------------------------
    // Fill datapath. The density is clamped once at start so the per-cell
    // compare is a plain 5-bit less-than; 16 makes every nibble pass.
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            map       <= '0;
            idx       <= '0;
            lfsr      <= LFSR_DEFAULT;
            density_q <= '0;
            occ_count <= '0;
        end else if (start_accept) begin
            lfsr      <= (seed == 16'h0000) ? LFSR_DEFAULT : seed;
            density_q <= (density > 5'd16) ? 5'd16 : density;
            idx       <= '0;
            occ_count <= '0;
        end else if (state == FILL) begin
            map[idx]  <= cell_bit;
            occ_count <= occ_count + 10'(cell_bit);
            idx       <= idx + 1'b1;
            lfsr      <= lfsr_next;
        end
    end

    //-------------------------------------------------------------------------
    // Read port. Sampling map with a non-blocking register gives the
    // pre-write value for a cell being written on the same edge.
    //-------------------------------------------------------------------------
    assign rd_valid = (32'(rd_x) < CELLS_X) && (32'(rd_y) < CELLS_Y);
    assign rd_lin   = IDX_W'(rd_y) * IDX_W'(CELLS_X) + IDX_W'(rd_x);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_occ <= 1'b0;
        end else begin
            rd_occ <= rd_valid ? map[rd_lin] : 1'b0;
        end
    end

endmodule

// File: tb/tb_random_map_writer.sv
//-----------------------------------------------------------------------------
// tb_random_map_writer
//
// Directed bench for random_map_writer at default parameters (32x24).
// Expected maps come from an LFSR reference model local to the bench plus a
// few hand-computed constants.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_random_map_writer;

    localparam int NCELLS = 768;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] seed;
    logic [4:0]  density;
    logic [4:0]  rd_x;
    logic [4:0]  rd_y;
    logic        rd_occ;
    logic        busy;
    logic        done;
    logic [9:0]  occ_count;

    int checks   = 0;
    int failures = 0;

    random_map_writer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .seed      (seed),
        .density   (density),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .rd_occ    (rd_occ),
        .busy      (busy),
        .done      (done),
        .occ_count (occ_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Reference map: same LFSR recurrence and threshold rule, done in software.
    function automatic logic [NCELLS-1:0] modelMap(input logic [15:0] s,
                                                   input logic [4:0] d);
        logic [15:0] lf;
        logic [4:0]  dc;
        logic [NCELLS-1:0] m;
        lf = (s == 16'h0) ? 16'hACE1 : s;
        dc = (d > 5'd16) ? 5'd16 : d;
        m  = '0;
        for (int i = 0; i < NCELLS; i++) begin
            m[i] = ({1'b0, lf[3:0]} < dc);
`ifdef SAFE_SPAWN_EN
            if ((i % 32) < 2 && (i / 32) < 2) m[i] = 1'b0;
`endif
            lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
        end
        return m;
    endfunction

    task automatic readCell(input int x, input int y, output logic v);
        rd_x = 5'(x);
        rd_y = 5'(y);
        @(posedge clk); #1;
        v = rd_occ;
    endtask

    task automatic readMap(output logic [NCELLS-1:0] m);
        logic v;
        m = '0;
        for (int y = 0; y < 24; y++) begin
            for (int x = 0; x < 32; x++) begin
                readCell(x, y, v);
                m[y*32 + x] = v;
            end
        end
    endtask

    // Runs one fill. restart_at / reset_at give the busy-cycle index at which
    // an extra start or a reset is driven (-1 disables).
    task automatic applyStimulus(input logic [15:0] s, input logic [4:0] d,
                                 input int restart_at, input int reset_at,
                                 output int busy_cycles, output int done_pulses,
                                 output logic idle_after);
        seed    = s;
        density = d;
        start   = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
        busy_cycles = 0;
        while (busy && busy_cycles < 2000) begin
            start = (busy_cycles == restart_at);
            rst   = (busy_cycles == reset_at);
            @(posedge clk); #1;
            busy_cycles++;
        end
        start       = 1'b0;
        rst         = 1'b0;
        done_pulses = int'(done);
        @(posedge clk); #1;
        done_pulses += int'(done);
        idle_after  = !busy && !done;
    endtask

    logic [NCELLS-1:0] m_a;
    logic [NCELLS-1:0] m_b;
    logic [NCELLS-1:0] exp_map;
    logic [9:0]        occ_a;
    logic              v;
    logic              idle_after;
    int                bc;
    int                dp;
    int                n;
    int                full_count;

    initial begin
`ifdef SAFE_SPAWN_EN
        full_count = 764;
`else
        full_count = 768;
`endif
        rst = 1'b1; start = 1'b0; seed = '0; density = '0; rd_x = '0; rd_y = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_done", 32'(done), 0);
        checkOutput("reset_occ_count", 32'(occ_count), 0);
        checkOutput("reset_rd_occ", 32'(rd_occ), 0);
        rst = 1'b0;
        readMap(m_a);
        checkOutput("reset_map_ones", $countones(m_a), 0);

        // Density 0: empty map, exact busy length, single done.
        applyStimulus(16'h0001, 5'd0, -1, -1, bc, dp, idle_after);
        checkOutput("d0_busy_cycles", bc, 768);
        checkOutput("d0_done_pulses", dp, 1);
        checkOutput("d0_occ_count", 32'(occ_count), 0);
        readMap(m_a);
        checkOutput("d0_map_ones", $countones(m_a), 0);

        // Density 31 clamps to 16: fully occupied apart from the spawn corner.
        applyStimulus(16'h0001, 5'd31, -1, -1, bc, dp, idle_after);
        checkOutput("d31_occ_count", 32'(occ_count), full_count);
        readMap(m_a);
        checkOutput("d31_map_ones", $countones(m_a), full_count);

        // Density 16, then boundary reads and the corner cells.
        applyStimulus(16'h0001, 5'd16, -1, -1, bc, dp, idle_after);
        checkOutput("d16_occ_count", 32'(occ_count), full_count);
        readMap(m_a);
        checkOutput("d16_map_ones", $countones(m_a), full_count);
`ifdef SAFE_SPAWN_EN
        checkOutput("spawn_cells", {28'b0, m_a[33], m_a[32], m_a[1], m_a[0]}, 0);
`else
        checkOutput("spawn_cells", {28'b0, m_a[33], m_a[32], m_a[1], m_a[0]}, 32'hF);
`endif
        readCell(31, 23, v);
        checkOutput("rd_last_cell", 32'(v), 1);
        readCell(5, 24, v);
        checkOutput("rd_y24", 32'(v), 0);
        readCell(0, 31, v);
        checkOutput("rd_y31", 32'(v), 0);
        readCell(31, 0, v);
        checkOutput("rd_x31_y0", 32'(v), 1);

        // occ_count holds through IDLE.
        repeat (10) @(posedge clk);
        #1;
        checkOutput("occ_hold_idle", 32'(occ_count), full_count);

        // Read during fill: cell 2 is written on the third FILL edge; the
        // read captured on that edge must still see the old 1.
        seed = 16'h0001; density = 5'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rd_x = 5'd2; rd_y = 5'd0;
        @(posedge clk); #1;
        checkOutput("fill_read_old", 32'(rd_occ), 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("fill_read_prewrite", 32'(rd_occ), 1);
        @(posedge clk); #1;
        checkOutput("fill_read_new", 32'(rd_occ), 0);
        n = 0;
        while (!done && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("fill_read_done_seen", 32'(done), 1);
        @(posedge clk); #1;

        // Hand-computed first cells for seed ACE1, density 8:
        // LFSR ACE1,59C3,B387,670F -> nibbles 1,3,7,F.
        applyStimulus(16'hACE1, 5'd8, -1, -1, bc, dp, idle_after);
        readMap(m_b);
`ifdef SAFE_SPAWN_EN
        checkOutput("ace1_first4", {28'b0, m_b[3:0]}, 32'h4);
`else
        checkOutput("ace1_first4", {28'b0, m_b[3:0]}, 32'h7);
`endif
        // Seed 0 substitutes ACE1.
        applyStimulus(16'h0000, 5'd8, -1, -1, bc, dp, idle_after);
        readMap(m_a);
        checkOutput("seed0_vs_ace1_diff", $countones(m_a ^ m_b), 0);

        // Two fills with the same seed give the same result, matching the model.
        exp_map = modelMap(16'h1234, 5'd8);
        applyStimulus(16'h1234, 5'd8, -1, -1, bc, dp, idle_after);
        occ_a = occ_count;
        readMap(m_a);
        checkOutput("s1234_occ_model", 32'(occ_a), $countones(exp_map));
        checkOutput("s1234_map_model_diff", $countones(m_a ^ exp_map), 0);
        applyStimulus(16'h1234, 5'd8, -1, -1, bc, dp, idle_after);
        readMap(m_b);
        checkOutput("s1234_repeat_occ", 32'(occ_count), 32'(occ_a));
        checkOutput("s1234_repeat_diff", $countones(m_a ^ m_b), 0);

        // Start during FILL is ignored and not queued.
        applyStimulus(16'h1234, 5'd8, 100, -1, bc, dp, idle_after);
        checkOutput("restart_busy_cycles", bc, 768);
        checkOutput("restart_done_pulses", dp, 1);
        checkOutput("restart_not_queued", 32'(idle_after), 1);

        // Reset mid-fill aborts without done and clears the map.
        applyStimulus(16'h1234, 5'd16, -1, 300, bc, dp, idle_after);
        checkOutput("abort_busy_cycles", bc, 301);
        checkOutput("abort_done_pulses", dp, 0);
        checkOutput("abort_occ_count", 32'(occ_count), 0);
        readMap(m_a);
        checkOutput("abort_map_ones", $countones(m_a), 0);

        // Reset wins over start on the same edge.
        rst = 1'b1; start = 1'b1; seed = 16'h0001; density = 5'd16;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        checkOutput("rst_priority_busy", 32'(busy), 0);
        @(posedge clk); #1;
        checkOutput("rst_priority_busy2", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
